sram_like_data_slave: RTL and testbench

- Responder end of the core's SRAM-like data interface (req / wr / size / addr / wdata / wstrb with addr_ok / data_ok / rdata).
- Accepts requests from the execute stage, holds up to DEPTH outstanding transactions, and answers them in order after a programmable latency.
- Backed by an internal word-addressed memory.
- Used as the data-side model and bring-up target for the memory stage before the AXI bridge is attached.

---
 rtl/sram_like_data_slave_pkg.sv | 29 ++
 rtl/sram_like_req_fifo.sv | 55 +++++
 rtl/sram_like_data_slave.sv | 115 +++++++++++
 tb/tb_sram_like_data_slave.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_data_slave_pkg.sv
// Shared types for the SRAM-like data slave: access-size encoding, service
// FSM states and the queued request entry.
package sram_like_data_slave_pkg;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'b000,
    SIZE_HALF = 3'b001,
    SIZE_WORD = 3'b010,
    SIZE_SWL  = 3'b100,
    SIZE_SWR  = 3'b101
  } size_t;

  typedef enum logic {
    IDLE,
    BUSY
  } svc_state_t;

  // word holds byte address bits [31:2]; the top module keeps only the low bits
  typedef struct packed {
    logic        wr;
    size_t       size;
    logic [29:0] word;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/sram_like_req_fifo.sv
// In-order holding queue for accepted requests waiting behind the one in service.
module sram_like_req_fifo
  import sram_like_data_slave_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  req_entry_t push_data,
  input  logic       pop,
  output req_entry_t pop_data,
  output logic       empty,
  output logic       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [ENTRY_W-1:0] slots [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign pop_data = req_entry_t'(slots[rd_ptr]);
  assign empty    = (occ == '0);
  assign full     = (occ == FULL_OCC);

endmodule

// File: rtl/sram_like_data_slave.sv
// SRAM-like data-side responder: accepts up to DEPTH outstanding requests and
// answers them in order, LATENCY cycles after acceptance, from an internal memory.
module sram_like_data_slave
  import sram_like_data_slave_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  input  logic        stall_addr,
  output logic        data_addr_ok,
  output logic        data_ok,
  output logic [31:0] data_rdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);

  svc_state_t        state, state_n;
  req_entry_t        svc, svc_n;
  req_entry_t        incoming, fifo_head;
  logic [LAT_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [ADDR_W-1:0] svc_idx;
  logic [31:0]       mem [2**ADDR_W];
  logic              unused_bits;

  assign incoming = '{wr: data_wr, size: size_t'(data_size), word: data_addr[31:2],
                      wdata: data_wdata, wstrb: data_wstrb};

  // count is the registered occupancy, so a slot freed this cycle is reused next cycle
  assign data_addr_ok = data_req & ~stall_addr & ~reset & (count < DEPTH_C);
  assign accept       = data_addr_ok;
  assign data_ok      = ~reset & (state == BUSY) & (cnt == '0);
  assign svc_idx      = svc.word[ADDR_W-1:0];
  assign data_rdata   = (data_ok && !svc.wr) ? mem[svc_idx] : '0;

  sram_like_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (incoming),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      svc   <= '0;
      cnt   <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      svc   <= svc_n;
      cnt   <= cnt_n;
      case ({accept, data_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The service slot reloads when idle or on its completing edge; queued work goes first
  always_comb begin
    state_n   = state;
    svc_n     = svc;
    cnt_n     = cnt;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (state == BUSY && cnt != '0) begin
      cnt_n     = cnt - 1'b1;
      fifo_push = accept;
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      fifo_push = accept;
      svc_n     = fifo_head;
      cnt_n     = LAT_INIT;
      state_n   = BUSY;
    end else if (accept) begin
      svc_n     = incoming;
      cnt_n     = LAT_INIT;
      state_n   = BUSY;
    end else begin
      state_n   = IDLE;
    end
  end

  // Memory is deliberately left out of reset so committed writes survive it
  always_ff @(posedge clk) begin
    if (data_ok && svc.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (svc.wstrb[i]) mem[svc_idx][8*i +: 8] <= svc.wdata[8*i +: 8];
      end
    end
  end

  assign unused_bits = ^{svc.size, svc.word[29:ADDR_W], data_addr[1:0], fifo_full};

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Randomised and directed bench for sram_like_data_slave against a
// completion-time queue model of the in-order, fixed-latency responder.
module tb_sram_like_data_slave;

  localparam int DEPTH = 2;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req, data_wr, stall_addr;
  logic [2:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_ok;
  logic [31:0] data_rdata;

  logic        req_b, wr_b, stall_b;
  logic [2:0]  size_b;
  logic [31:0] addr_b, wdata_b;
  logic [3:0]  wstrb_b;
  logic        addr_ok_b, ok_b;
  logic [31:0] rdata_b;

  always #5 clk = ~clk;

  sram_like_data_slave #(.ADDR_W(10), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .stall_addr(stall_addr), .data_addr_ok(data_addr_ok),
    .data_ok(data_ok), .data_rdata(data_rdata)
  );

  sram_like_data_slave #(.ADDR_W(10), .DEPTH(2), .LATENCY(1)) dut_lat1 (
    .clk(clk), .reset(reset), .data_req(req_b), .data_wr(wr_b),
    .data_size(size_b), .data_addr(addr_b), .data_wdata(wdata_b),
    .data_wstrb(wstrb_b), .stall_addr(stall_b), .data_addr_ok(addr_ok_b),
    .data_ok(ok_b), .data_rdata(rdata_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: each outstanding transaction knows the cycle it completes in
  typedef struct {
    logic        wr;
    int unsigned word;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          done;
  } txn_t;

  txn_t        model_q[$];
  logic [31:0] model_mem [1024];
  int          cyc = 0;
  int          ok_seen = 0;
  logic [31:0] last_rdata = 32'h0;

  always @(negedge clk) begin : monitor
    logic        exp_ok, exp_aok;
    logic [31:0] exp_rd;
    txn_t        t;
    int          prev;
    exp_ok  = !reset && model_q.size() > 0 && model_q[0].done == cyc;
    exp_rd  = 32'h0;
    if (exp_ok && !model_q[0].wr) exp_rd = model_mem[model_q[0].word];
    exp_aok = data_req && !stall_addr && !reset && (model_q.size() < DEPTH);
    checkOutput("addr_ok", {31'b0, data_addr_ok}, {31'b0, exp_aok});
    checkOutput("data_ok", {31'b0, data_ok}, {31'b0, exp_ok});
    checkOutput("rdata", data_rdata, exp_rd);
    if (data_ok) ok_seen++;
    if (exp_ok && !model_q[0].wr) last_rdata = data_rdata;
    if (reset) begin
      model_q.delete();
    end else begin
      if (exp_ok) begin
        t = model_q.pop_front();
        if (t.wr)
          for (int i = 0; i < 4; i++)
            if (t.wstrb[i]) model_mem[t.word][8*i +: 8] = t.wdata[8*i +: 8];
      end
      if (exp_aok) begin
        prev    = (model_q.size() > 0 && model_q[$].done > cyc) ? model_q[$].done : cyc;
        t.wr    = data_wr;
        t.word  = int'(data_addr[11:2]);
        t.wdata = data_wdata;
        t.wstrb = data_wstrb;
        t.done  = prev + LAT;
        model_q.push_back(t);
      end
    end
    cyc++;
  end

  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic stall, input logic rst);
    data_req   = req;
    data_wr    = wr;
    data_addr  = addr;
    data_wdata = wdata;
    data_wstrb = strb;
    stall_addr = stall;
    reset      = rst;
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; waits reports how many cycles addr_ok was low
  task automatic sendReq(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output int waits);
    logic acc;
    acc        = 1'b0;
    waits      = 0;
    data_req   = 1'b1;
    data_wr    = wr;
    data_addr  = addr;
    data_wdata = wdata;
    data_wstrb = strb;
    data_size  = 3'b010;
    stall_addr = 1'b0;
    reset      = 1'b0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = data_addr_ok;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    data_req = 1'b0;
    if (!acc) checkOutput("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (model_q.size() > 0 && n < 60) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      n++;
    end
    if (model_q.size() > 0) checkOutput("drain_timeout", model_q.size(), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] pre [16];
  logic [31:0] vals [4];
  int          waits;
  int          base;

  initial begin
    reset = 1'b1; data_req = 1'b1; data_wr = 1'b0; stall_addr = 1'b0; data_size = 3'b010;
    data_addr = 32'h0; data_wdata = 32'h0; data_wstrb = 4'h0;
    req_b = 1'b0; wr_b = 1'b0; stall_b = 1'b0; size_b = 3'b010;
    addr_b = 32'h0; wdata_b = 32'h0; wstrb_b = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    data_req = 1'b0;

    for (int w = 0; w < 16; w++) begin
      pre[w] = $urandom;
      sendReq(1'b1, 32'(w * 4), pre[w], 4'hF, waits);
    end
    drain();

    sendReq(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, waits);
    sendReq(1'b0, 32'h10, 32'h0, 4'h0, waits);
    drain();
    checkOutput("t1_read", last_rdata, 32'hDEADBEEF);

    sendReq(1'b1, 32'h10, 32'h0000AB00, 4'b0010, waits);
    sendReq(1'b0, 32'h10, 32'h0, 4'h0, waits);
    drain();
    checkOutput("t2_read", last_rdata, 32'hDEADABEF);

    base = ok_seen;
    sendReq(1'b0, 32'h0, 32'h0, 4'h0, waits);
    checkOutput("t3_wait1", waits, 32'd0);
    sendReq(1'b0, 32'h4, 32'h0, 4'h0, waits);
    checkOutput("t3_wait2", waits, 32'd0);
    sendReq(1'b0, 32'h8, 32'h0, 4'h0, waits);
    checkOutput("t3_wait3", waits, 32'd1);
    drain();
    checkOutput("t3_oks", ok_seen - base, 32'd3);
    checkOutput("t3_last", last_rdata, pre[2]);

    base = ok_seen;
    sendReq(1'b0, 32'h8, 32'h0, 4'h0, waits);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("t4_ok_in_stall", ok_seen - base, 32'd1);
    sendReq(1'b0, 32'hC, 32'h0, 4'h0, waits);
    checkOutput("t4_resume_wait", waits, 32'd0);
    drain();
    checkOutput("t4_read", last_rdata, pre[3]);

    base = ok_seen;
    sendReq(1'b1, 32'h20, 32'h11111111, 4'hF, waits);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    sendReq(1'b0, 32'h20, 32'h0, 4'h0, waits);
    checkOutput("t5_resume_wait", waits, 32'd0);
    drain();
    checkOutput("t5_dropped_write", last_rdata, pre[8]);
    checkOutput("t5_oks", ok_seen - base, 32'd1);
    sendReq(1'b0, 32'h10, 32'h0, 4'h0, waits);
    drain();
    checkOutput("t5_persist", last_rdata, 32'hDEADABEF);

    repeat (400) begin
      data_size = 3'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    drain();

    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 5; i++) begin
        req_b   = (i < 4);
        wr_b    = (ph == 0);
        addr_b  = 32'(i * 4);
        wdata_b = (i < 4) ? vals[i] : 32'h0;
        wstrb_b = 4'hF;
        @(negedge clk);
        if (i < 4) checkOutput("t6_addr_ok", {31'b0, addr_ok_b}, 32'd1);
        if (i > 0) begin
          checkOutput("t6_data_ok", {31'b0, ok_b}, 32'd1);
          checkOutput("t6_rdata", rdata_b, (ph == 1) ? vals[i-1] : 32'h0);
        end
        @(posedge clk);
        #1;
      end
      req_b = 1'b0;
      @(negedge clk);
      checkOutput("t6_quiet", {31'b0, ok_b}, 32'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
